// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// aes_pkg : shared AES constants, types and GF(2^8) helpers
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int AES_NR = 10;
  localparam int ADDR_W = 4;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_t;

  localparam logic [7:0] RCON_TAB [AES_NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
//------------------------------------------------------------------------------
// aes_sbox : combinational AES byte substitution (GF inverse + affine map)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  import aes_pkg::*;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] w_inv;

  assign w_inv  = gf_inv(i_byte);
  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule

`default_nettype wire

// File: rtl/aes_key_expand.sv
//------------------------------------------------------------------------------
// aes_key_expand : sequential AES-128 key schedule, one round key per cycle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aes_key_expand #(
  parameter int NUM_ROUNDS = aes_pkg::AES_NR,
  parameter int ADDR_W     = aes_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [127:0]      key_in,
  output logic [127:0]      rkey,
  output logic [ADDR_W-1:0] addr,
  output logic              rkey_valid,
  output logic              busy,
  output logic              done
);

  import aes_pkg::*;

  localparam logic [ADDR_W-1:0] c_last_run_addr = ADDR_W'(NUM_ROUNDS - 1);

  state_t            r_state, w_state_nxt;
  logic [127:0]      r_rkey, w_rkey_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [7:0]        r_rcon, w_rcon_nxt;

  word_t w_w0, w_w1, w_w2, w_w3;
  word_t w_rot, w_sub, w_t;
  word_t w_n0, w_n1, w_n2, w_n3;

  assign w_w0  = r_rkey[127:96];
  assign w_w1  = r_rkey[95:64];
  assign w_w2  = r_rkey[63:32];
  assign w_w3  = r_rkey[31:0];
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*i +: 8]),
      .o_byte (w_sub[8*i +: 8])
    );
  end

  assign w_t  = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rkey  <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rcon  <= RCON_TAB[0];
    end else begin
      r_state <= w_state_nxt;
      r_rkey  <= w_rkey_nxt;
      r_addr  <= w_addr_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rcon  <= w_rcon_nxt;
    end
  end

  // rkey/addr hold outside RUN so consumers see the last key until restart
  always_comb begin
    w_state_nxt = r_state;
    w_rkey_nxt  = r_rkey;
    w_addr_nxt  = r_addr;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_rcon_nxt  = r_rcon;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_rkey_nxt  = key_in;
          w_addr_nxt  = '0;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_rcon_nxt  = RCON_TAB[0];
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_rkey_nxt = {w_n0, w_n1, w_n2, w_n3};
        w_addr_nxt = r_addr + ADDR_W'(1);
        w_rcon_nxt = xtime(r_rcon);
        if (r_addr == c_last_run_addr) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_LAST;
        end
      end
      ST_LAST: begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign rkey       = r_rkey;
  assign addr       = r_addr;
  assign rkey_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

`default_nettype wire
